pwm_capture: RTL and testbench



---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_sync_edge.sv | 35 +++
 rtl/pwm_capture.sv | 161 ++++++++++++++++
 tb/tb_pwm_capture.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

    localparam int PWM_CNT_W       = 16;
    localparam int PWM_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        STUCK
    } cap_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronises an asynchronous PWM input and flags its rising/falling edges.
// Latency: level appears SYNC_STAGES edges after pwm_in; rise/fall are combinational from level and its delayed copy.
// Backpressure: none, free-running.
module pwm_sync_edge
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = PWM_SYNC_STAGES  // must be >= 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pwm,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    // Synchroniser chain plus one delay flop for edge detection; all clear on reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_dly;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_dly;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input in clk cycles; flags stuck-high/low.
// Latency: meas_valid SYNC_STAGES+1 edges after the closing pwm_in rise; one-cycle strobe.
// Backpressure: none; consumer must sample on meas_valid.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             stuck_high,
    output logic             stuck_low,
    output logic             level
);

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic w_level, w_rise, w_fall;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_pwm  (pwm_in),
        .o_level(w_level),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    cap_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_hi, w_hi_nxt;
    logic [CNT_W-1:0] r_high_cnt, w_high_nxt;
    logic [CNT_W-1:0] r_period_cnt, w_period_nxt;
    logic             r_meas_valid, w_valid_nxt;
    logic             r_stuck_high, w_sh_nxt;
    logic             r_stuck_low, w_sl_nxt;

    logic             w_at_max;
    logic             w_no_edge;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_at_max  = (r_cnt == MAX);
    assign w_no_edge = ~w_rise & ~w_fall;
    // Counter saturates at MAX instead of wrapping
    assign w_cnt_inc = w_at_max ? MAX : (r_cnt + ONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter, latch and flag logic; an edge always beats saturation
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hi_nxt     = r_hi;
        w_high_nxt   = r_high_cnt;
        w_period_nxt = r_period_cnt;
        w_valid_nxt  = 1'b0;
        w_sh_nxt     = r_stuck_high;
        w_sl_nxt     = r_stuck_low;

        case (r_state)
            IDLE: begin
                // Period before the first rise is never published
                if (w_rise) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = ONE;
                end else if (w_at_max && w_no_edge) begin
                    w_state_nxt = STUCK;
                    w_sh_nxt    = w_level;
                    w_sl_nxt    = ~w_level;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_hi_nxt    = r_cnt;
                    w_state_nxt = LOW;
                    w_cnt_nxt   = w_cnt_inc;
                end else if (w_at_max && w_no_edge) begin
                    w_state_nxt = STUCK;
                    w_sh_nxt    = w_level;
                    w_sl_nxt    = ~w_level;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_period_nxt = r_cnt;
                    w_high_nxt   = r_hi;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = HIGH;
                    w_cnt_nxt    = ONE;
                end else if (w_at_max && w_no_edge) begin
                    w_state_nxt = STUCK;
                    w_sh_nxt    = w_level;
                    w_sl_nxt    = ~w_level;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            STUCK: begin
                // Recovery rise restarts measurement without publishing
                if (w_rise) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = ONE;
                    w_sh_nxt    = 1'b0;
                    w_sl_nxt    = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Counter, high-time latch, published measurements and stuck flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_hi         <= '0;
            r_high_cnt   <= '0;
            r_period_cnt <= '0;
            r_meas_valid <= 1'b0;
            r_stuck_high <= 1'b0;
            r_stuck_low  <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_hi         <= w_hi_nxt;
            r_high_cnt   <= w_high_nxt;
            r_period_cnt <= w_period_nxt;
            r_meas_valid <= w_valid_nxt;
            r_stuck_high <= w_sh_nxt;
            r_stuck_low  <= w_sl_nxt;
        end
    end

    assign high_cnt   = r_high_cnt;
    assign period_cnt = r_period_cnt;
    assign meas_valid = r_meas_valid;
    assign stuck_high = r_stuck_high;
    assign stuck_low  = r_stuck_low;
    assign level      = w_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (CNT_W=8 so saturation is reachable quickly).
// Latency: strobes expected SYNC_STAGES+1 = 3 edges after the closing pwm_in rise.
// Backpressure: none.
module tb_pwm_capture;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pwm_in = 1'b0;
    logic [CW-1:0] high_cnt;
    logic [CW-1:0] period_cnt;
    logic          meas_valid;
    logic          stuck_high;
    logic          stuck_low;
    logic          level;

    always #5 clk = ~clk;

    pwm_capture #(
        .CNT_W      (CW),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .high_cnt  (high_cnt),
        .period_cnt(period_cnt),
        .meas_valid(meas_valid),
        .stuck_high(stuck_high),
        .stuck_low (stuck_low),
        .level     (level)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // observed strobes, expected strobes, and edge labels at which pwm_in rose
    int q_cyc[$], q_hi[$], q_per[$];
    int exp_cyc[$], exp_hi[$], exp_per[$];
    int rise_q[$];
    int sh_rise, sh_fall, sl_rise;
    logic prev_sh, prev_sl;

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one edge, sample #1 later, log strobes and flag transitions
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (meas_valid) begin
            q_cyc.push_back(cyc);
            q_hi.push_back(int'(high_cnt));
            q_per.push_back(int'(period_cnt));
        end
        if (stuck_high && !prev_sh) sh_rise = cyc;
        if (!stuck_high && prev_sh) sh_fall = cyc;
        if (stuck_low && !prev_sl) sl_rise = cyc;
        prev_sh = stuck_high;
        prev_sl = stuck_low;
    endtask

    task automatic drive(logic v, int n);
        repeat (n) begin
            if (v && !pwm_in) rise_q.push_back(cyc + 1);
            pwm_in = v;
            tick();
        end
    endtask

    task automatic steady(int hi, int lo, int n);
        repeat (n) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    task automatic clear_logs();
        q_cyc.delete();   q_hi.delete();   q_per.delete();
        exp_cyc.delete(); exp_hi.delete(); exp_per.delete();
        rise_q.delete();
        sh_rise = -1; sh_fall = -1; sl_rise = -1;
        prev_sh = stuck_high;
        prev_sl = stuck_low;
    endtask

    task automatic expect_strobe(int c, int h, int p);
        exp_cyc.push_back(c);
        exp_hi.push_back(h);
        exp_per.push_back(p);
    endtask

    task automatic verify(string tag);
        int n;
        check($sformatf("%s_count", tag), q_cyc.size(), exp_cyc.size());
        n = (q_cyc.size() < exp_cyc.size()) ? q_cyc.size() : exp_cyc.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_cyc%0d", tag, i), q_cyc[i], exp_cyc[i]);
            check($sformatf("%s_hi%0d", tag, i), q_hi[i], exp_hi[i]);
            check($sformatf("%s_per%0d", tag, i), q_per[i], exp_per[i]);
        end
    endtask

    task automatic do_reset();
        pwm_in = 1'b0;
        rst    = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
    endtask

    task automatic check_zero(string tag);
        check({tag, "_high"},   int'(high_cnt),   0);
        check({tag, "_period"}, int'(period_cnt), 0);
        check({tag, "_valid"},  int'(meas_valid), 0);
        check({tag, "_sh"},     int'(stuck_high), 0);
        check({tag, "_sl"},     int'(stuck_low),  0);
        check({tag, "_level"},  int'(level),      0);
    endtask

    initial begin
        // reset state
        do_reset();
        check_zero("reset");

        // steady 3/5: first strobe 3 edges after 2nd rise, then every 8
        clear_logs();
        drive(1'b0, 4);
        steady(3, 5, 4);
        drive(1'b1, 1);
        drive(1'b0, 4);
        for (int i = 1; i <= 4; i++) expect_strobe(rise_q[i] + 2, 3, 8);
        verify("steady");

        // duty change 3/5 -> 6/2 at a period boundary
        do_reset();
        clear_logs();
        drive(1'b0, 3);
        steady(3, 5, 2);
        steady(6, 2, 2);
        drive(1'b1, 1);
        drive(1'b0, 4);
        expect_strobe(rise_q[1] + 2, 3, 8);
        expect_strobe(rise_q[2] + 2, 3, 8);
        expect_strobe(rise_q[3] + 2, 6, 8);
        expect_strobe(rise_q[4] + 2, 6, 8);
        verify("duty");
        if (q_cyc.size() >= 3) check("duty_gap", q_cyc[2] - q_cyc[1], 8);

        // minimum pulses 1/1
        do_reset();
        clear_logs();
        drive(1'b0, 2);
        steady(1, 1, 6);
        drive(1'b0, 4);
        for (int i = 1; i <= 5; i++) expect_strobe(rise_q[i] + 2, 1, 2);
        verify("minpulse");

        // stuck high: cnt reaches 255 at edge rise+256, flag at rise+257
        do_reset();
        clear_logs();
        drive(1'b0, 2);
        steady(3, 5, 2);
        drive(1'b1, 300);
        check("sh_flag_on", int'(stuck_high), 1);
        drive(1'b0, 4);
        steady(4, 4, 3);
        drive(1'b0, 4);
        expect_strobe(rise_q[1] + 2, 3, 8);
        expect_strobe(rise_q[2] + 2, 3, 8);
        expect_strobe(rise_q[4] + 2, 4, 8);
        expect_strobe(rise_q[5] + 2, 4, 8);
        verify("stuckhi");
        check("sh_rise_cyc", sh_rise, rise_q[2] + 257);
        check("sh_clear_cyc", sh_fall, rise_q[3] + 2);
        check("sh_no_sl", sl_rise, -1);

        // stuck low: outputs hold last measurement
        do_reset();
        clear_logs();
        drive(1'b0, 2);
        steady(3, 5, 2);
        drive(1'b1, 3);
        drive(1'b0, 300);
        expect_strobe(rise_q[1] + 2, 3, 8);
        expect_strobe(rise_q[2] + 2, 3, 8);
        verify("stucklo");
        check("sl_rise_cyc", sl_rise, rise_q[2] + 257);
        check("sl_flag", int'(stuck_low), 1);
        check("sl_no_sh", int'(stuck_high), 0);
        check("sl_hold_high", int'(high_cnt), 3);
        check("sl_hold_period", int'(period_cnt), 8);
        check("sl_level", int'(level), 0);

        // reset mid-high: pwm_in stays high through reset, rise after release starts from IDLE
        do_reset();
        clear_logs();
        drive(1'b0, 2);
        steady(3, 5, 2);
        check("rm_pre_high", int'(high_cnt), 3);
        drive(1'b1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rm");
        clear_logs();
        drive(1'b1, 3);
        drive(1'b0, 5);
        steady(3, 5, 2);
        drive(1'b1, 1);
        drive(1'b0, 4);
        for (int i = 0; i <= 2; i++) expect_strobe(rise_q[i] + 2, 3, 8);
        verify("rstmid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
